// File: rtl/multicycle_control_unit_if.sv
// Control-unit to datapath bundle: decoded instruction fields and the ALU zero
// flag flow in; every datapath enable and mux select flows out.
interface multicycle_control_unit_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       PC_write;
    logic       adr_src;
    logic       mem_write;
    logic       IR_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] ALU_src_A;
    logic [1:0] ALU_src_B;
    logic [2:0] imm_src;
    logic [3:0] ALU_control;
    logic       illegal;

    modport master (
        input  opcode, funct3, funct7_5, zero,
        output PC_write, adr_src, mem_write, IR_write, reg_write,
        output result_src, ALU_src_A, ALU_src_B, imm_src, ALU_control, illegal
    );

    modport slave (
        output opcode, funct3, funct7_5, zero,
        input  PC_write, adr_src, mem_write, IR_write, reg_write,
        input  result_src, ALU_src_A, ALU_src_B, imm_src, ALU_control, illegal
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for a multicycle RV32I core: sequences fetch, decode,
// memory access, ALU work, branch resolution and write-back per opcode class.
module multicycle_control_unit #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic                      CLOCK,
    input  logic                      RESET,
    multicycle_control_unit_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_JALR1, S_JALR2,
        S_BRANCH, S_LUI, S_AUIPC, S_ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1001;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;
    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_IMM   = 2'b01;
    localparam logic [1:0] SRC_B_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    state_t     r_state;
    state_t     w_next;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_take;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic [1:0] w_result_src;
    logic [1:0] w_src_a;
    logic [1:0] w_src_b;
    logic [2:0] w_imm_src;
    logic [3:0] w_alu;
    logic       w_illegal;

    // funct7_5 selects SUB only for register-register ops; shifts honour it in both forms.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7_5,
                                              input logic is_r);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_r && f7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic branch_legal(input logic [2:0] f3);
        return f3[2:1] != 2'b01;
    endfunction

    function automatic logic [3:0] branch_alu(input logic [2:0] f3);
        logic [3:0] op;
        case (f3[2:1])
            2'b00:   op = ALU_SUB;
            2'b10:   op = ALU_SLT;
            default: op = ALU_SLTU;
        endcase
        return op;
    endfunction

    // BEQ/BGE/BGEU take on a zero result; BNE/BLT/BLTU on a non-zero one.
    function automatic logic branch_take(input logic [2:0] f3, input logic z);
        logic t;
        case (f3)
            3'b000, 3'b101, 3'b111: t = z;
            default:                t = ~z;
        endcase
        return t;
    endfunction

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXECR;
                    OP_I:              w_next = S_EXECI;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR1;
                    OP_BRANCH:         w_next = branch_legal(bus.funct3) ? S_BRANCH : S_ILLEGAL;
                    OP_LUI:            w_next = S_LUI;
                    OP_AUIPC:          w_next = S_AUIPC;
                    default:           w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   w_next = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = S_FETCH;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_JALR1:    w_next = S_JALR2;
            S_JALR2:    w_next = S_ALUWB;
            S_BRANCH:   w_next = S_FETCH;
            S_LUI:      w_next = S_ALUWB;
            S_AUIPC:    w_next = S_ALUWB;
            S_ILLEGAL:  w_next = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_result_src = RES_ALUOUT;
        w_src_a      = SRC_A_PC;
        w_src_b      = SRC_B_RS2;
        w_alu        = ALU_ADD;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_pc_update  = 1'b1;
                w_src_a      = SRC_A_PC;
                w_src_b      = SRC_B_FOUR;
                w_result_src = RES_ALU;
            end
            // Branch/JAL target is precomputed here into ALU_out.
            S_DECODE: begin
                w_src_a = SRC_A_OLDPC;
                w_src_b = SRC_B_IMM;
            end
            S_MEMADR: begin
                w_src_a = SRC_A_RS1;
                w_src_b = SRC_B_IMM;
            end
            S_MEMREAD: begin
                w_adr_src = 1'b1;
            end
            S_MEMWB: begin
                w_result_src = RES_MEM;
                w_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                w_src_a = SRC_A_RS1;
                w_src_b = SRC_B_RS2;
                w_alu   = alu_decode(bus.funct3, bus.funct7_5, 1'b1);
            end
            S_EXECI: begin
                w_src_a = SRC_A_RS1;
                w_src_b = SRC_B_IMM;
                w_alu   = alu_decode(bus.funct3, bus.funct7_5, 1'b0);
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
            end
            S_JAL, S_JALR2: begin
                w_src_a     = SRC_A_OLDPC;
                w_src_b     = SRC_B_FOUR;
                w_pc_update = 1'b1;
            end
            S_JALR1: begin
                w_src_a = SRC_A_RS1;
                w_src_b = SRC_B_IMM;
            end
            S_BRANCH: begin
                w_src_a  = SRC_A_RS1;
                w_src_b  = SRC_B_RS2;
                w_alu    = branch_alu(bus.funct3);
                w_branch = 1'b1;
            end
            S_LUI: begin
                w_src_a = SRC_A_ZERO;
                w_src_b = SRC_B_IMM;
            end
            S_AUIPC: begin
                w_src_a = SRC_A_OLDPC;
                w_src_b = SRC_B_IMM;
            end
            S_ILLEGAL: begin
                w_illegal = 1'b1;
            end
            default: begin
                w_illegal = 1'b0;
            end
        endcase
    end

    always_comb begin
        case (bus.opcode)
            OP_STORE:         w_imm_src = 3'b001;
            OP_BRANCH:        w_imm_src = 3'b010;
            OP_JAL:           w_imm_src = 3'b011;
            OP_LUI, OP_AUIPC: w_imm_src = 3'b100;
            default:          w_imm_src = 3'b000;
        endcase
    end

    assign w_take = branch_take(bus.funct3, bus.zero);

    // Enables are masked while RESET is high so an aborted instruction writes nothing.
    assign bus.PC_write    = ~RESET & (w_pc_update | (w_branch & w_take));
    assign bus.IR_write    = ~RESET & w_ir_write;
    assign bus.mem_write   = ~RESET & w_mem_write;
    assign bus.reg_write   = ~RESET & w_reg_write;
    assign bus.adr_src     = w_adr_src;
    assign bus.result_src  = w_result_src;
    assign bus.ALU_src_A   = w_src_a;
    assign bus.ALU_src_B   = w_src_b;
    assign bus.imm_src     = w_imm_src;
    assign bus.ALU_control = w_alu;
    assign bus.illegal     = w_illegal;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: halting and non-halting instances
// run side by side against a per-instruction cycle table model.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic       regw;
        logic [1:0] rs;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       ill;
    } outv_t;

    typedef enum int {C_LOAD, C_STORE, C_R, C_I, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL} icls_t;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR = 7'b1100011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] op_d = 7'd0;
    logic [2:0] f3_d = 3'd0;
    logic       f75_d = 1'b0;
    logic       z_d = 1'b0;
    int         checks = 0;
    int         errors = 0;
    outv_t      exp_h, exp_n, msk_h, msk_n, act_h, act_n;
    bit         chk_en = 1'b0;
    bit         halted_h = 1'b0;
    bit         pin_halt = 1'b0;

    multicycle_control_unit_if if_h ();
    multicycle_control_unit_if if_n ();

    assign if_h.opcode = op_d;  assign if_n.opcode = op_d;
    assign if_h.funct3 = f3_d;  assign if_n.funct3 = f3_d;
    assign if_h.funct7_5 = f75_d; assign if_n.funct7_5 = f75_d;
    assign if_h.zero = z_d;     assign if_n.zero = z_d;

    multicycle_control_unit #(.ILLEGAL_HALT(1'b1)) dut_h (.CLOCK(clk), .RESET(rst), .bus(if_h));
    multicycle_control_unit #(.ILLEGAL_HALT(1'b0)) dut_n (.CLOCK(clk), .RESET(rst), .bus(if_n));

    assign act_h = {if_h.PC_write, if_h.adr_src, if_h.mem_write, if_h.IR_write, if_h.reg_write,
                    if_h.result_src, if_h.ALU_src_A, if_h.ALU_src_B, if_h.imm_src,
                    if_h.ALU_control, if_h.illegal};
    assign act_n = {if_n.PC_write, if_n.adr_src, if_n.mem_write, if_n.IR_write, if_n.reg_write,
                    if_n.result_src, if_n.ALU_src_A, if_n.ALU_src_B, if_n.imm_src,
                    if_n.ALU_control, if_n.illegal};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (((act_h ^ exp_h) & msk_h) !== '0) begin
                errors++;
                $display("FAIL cycle_halt t=%0t act=%h exp=%h mask=%h", $time, act_h, exp_h, msk_h);
            end
            checks++;
            if (((act_n ^ exp_n) & msk_n) !== '0) begin
                errors++;
                $display("FAIL cycle_nohalt t=%0t act=%h exp=%h mask=%h", $time, act_n, exp_n, msk_n);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s t=%0t act=%0h exp=%0h", name, $time, act, expv);
        end
    endtask

    function automatic icls_t classify(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            OP_LOAD:  return C_LOAD;
            OP_STORE: return C_STORE;
            OP_R:     return C_R;
            OP_I:     return C_I;
            OP_JAL:   return C_JAL;
            OP_JALR:  return C_JALR;
            OP_BR:    return (f3 == 3'b010 || f3 == 3'b011) ? C_ILL : C_BR;
            OP_LUI:   return C_LUI;
            OP_AUIPC: return C_AUIPC;
            default:  return C_ILL;
        endcase
    endfunction

    function automatic int ilen(input icls_t c);
        case (c)
            C_LOAD, C_JALR: return 5;
            C_BR, C_ILL:    return 3;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            OP_STORE:         return 3'b001;
            OP_BR:            return 3'b010;
            OP_JAL:           return 3'b011;
            OP_LUI, OP_AUIPC: return 3'b100;
            default:          return 3'b000;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f75, input bit is_r);
        case (f3)
            3'd0:    return (is_r && f75) ? 4'b0001 : 4'b0000;
            3'd1:    return 4'b0101;
            3'd2:    return 4'b1001;
            3'd3:    return 4'b1000;
            3'd4:    return 4'b0100;
            3'd5:    return f75 ? 4'b0111 : 4'b0110;
            3'd6:    return 4'b0011;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic logic [3:0] bop(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd1: return 4'b0001;
            3'd4, 3'd5: return 4'b1001;
            default:    return 4'b1000;
        endcase
    endfunction

    function automatic logic btake(input logic [2:0] f3, input logic z);
        case (f3)
            3'd0, 3'd5, 3'd7: return z;
            default:          return !z;
        endcase
    endfunction

    // Expected outputs in cycle k (0 = fetch) of the instruction (op, f3, f75).
    function automatic void model(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                                  input logic z, input int k, input logic [6:0] op_now,
                                  output outv_t e, output outv_t m);
        icls_t      c;
        logic [1:0] a, b, rs;
        logic [3:0] alu;
        logic       adr;
        bit         cab, crs, cadr;
        c = classify(op, f3);
        e = '0; m = '0;
        a = 2'd0; b = 2'd0; rs = 2'd0; alu = 4'd0; adr = 1'b0;
        cab = 1'b0; crs = 1'b0; cadr = 1'b0;
        m.pcw = 1'b1; m.memw = 1'b1; m.irw = 1'b1; m.regw = 1'b1; m.ill = 1'b1; m.imm = '1;
        e.imm = imm_of(op_now);
        if (k == 0) begin
            e.irw = 1'b1; e.pcw = 1'b1; cadr = 1'b1;
            a = 2'd0; b = 2'd2; cab = 1'b1; rs = 2'd2; crs = 1'b1;
        end else if (k == 1) begin
            a = 2'd1; b = 2'd1; cab = 1'b1;
        end else begin
            case (c)
                C_LOAD: begin
                    if (k == 2) begin a = 2'd2; b = 2'd1; cab = 1'b1; end
                    else if (k == 3) begin adr = 1'b1; cadr = 1'b1; crs = 1'b1; end
                    else begin rs = 2'd1; crs = 1'b1; e.regw = 1'b1; end
                end
                C_STORE: begin
                    if (k == 2) begin a = 2'd2; b = 2'd1; cab = 1'b1; end
                    else begin adr = 1'b1; cadr = 1'b1; crs = 1'b1; e.memw = 1'b1; end
                end
                C_R, C_I: begin
                    if (k == 2) begin
                        a = 2'd2; b = (c == C_R) ? 2'd0 : 2'd1; cab = 1'b1;
                        alu = alu_of(f3, f75, c == C_R);
                    end else begin crs = 1'b1; e.regw = 1'b1; end
                end
                C_JAL: begin
                    if (k == 2) begin a = 2'd1; b = 2'd2; cab = 1'b1; crs = 1'b1; e.pcw = 1'b1; end
                    else begin crs = 1'b1; e.regw = 1'b1; end
                end
                C_JALR: begin
                    if (k == 2) begin a = 2'd2; b = 2'd1; cab = 1'b1; end
                    else if (k == 3) begin a = 2'd1; b = 2'd2; cab = 1'b1; crs = 1'b1; e.pcw = 1'b1; end
                    else begin crs = 1'b1; e.regw = 1'b1; end
                end
                C_BR: begin
                    a = 2'd2; b = 2'd0; alu = bop(f3); cab = 1'b1; crs = 1'b1;
                    e.pcw = btake(f3, z);
                end
                C_LUI, C_AUIPC: begin
                    if (k == 2) begin a = (c == C_LUI) ? 2'd3 : 2'd1; b = 2'd1; cab = 1'b1; end
                    else begin crs = 1'b1; e.regw = 1'b1; end
                end
                default: e.ill = 1'b1;
            endcase
        end
        e.a = a; e.b = b; e.alu = alu; e.rs = rs; e.adr = adr;
        if (cab) begin m.a = '1; m.b = '1; m.alu = '1; end
        if (crs) m.rs = '1;
        if (cadr) m.adr = 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_step(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                           input logic z, input int k);
        outv_t e, m;
        if (k == 0) begin
            op_d = 7'($urandom); f3_d = 3'($urandom); f75_d = 1'($urandom);
        end else begin
            op_d = op; f3_d = f3; f75_d = f75;
        end
        z_d = z;
        model(op, f3, f75, z, k, op_d, e, m);
        exp_n = e; msk_n = m;
        if (halted_h) begin
            exp_h = '0; exp_h.ill = 1'b1; exp_h.imm = imm_of(op_d);
            msk_h = '0; msk_h.pcw = 1'b1; msk_h.memw = 1'b1; msk_h.irw = 1'b1;
            msk_h.regw = 1'b1; msk_h.ill = 1'b1; msk_h.imm = '1;
        end else begin
            exp_h = e; msk_h = m;
        end
        if (classify(op, f3) == C_ILL && k == 2) halted_h = 1'b1;
        chk_en = 1'b1;
        #1;
        if (pin_halt) begin
            lit("halt_illegal", 32'(if_h.illegal), 32'd1);
            lit("halt_enables", 32'({if_h.PC_write, if_h.mem_write, if_h.IR_write, if_h.reg_write}), 32'd0);
        end
    endtask

    task automatic steps(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                         input int from, input int upto);
        for (int k = from; k < upto; k++) begin
            do_step(op, f3, f75, 1'($urandom), k);
            tick();
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75);
        steps(op, f3, f75, 0, ilen(classify(op, f3)));
    endtask

    task automatic rand_instr(input bit allow_ill);
        logic [6:0] op;
        logic [2:0] f3;
        int         sel;
        sel = $urandom_range(0, allow_ill ? 9 : 8);
        case (sel)
            0: op = OP_LOAD;  1: op = OP_STORE; 2: op = OP_R;   3: op = OP_I;
            4: op = OP_JAL;   5: op = OP_JALR;  6: op = OP_BR;  7: op = OP_LUI;
            8: op = OP_AUIPC; default: op = 7'($urandom);
        endcase
        f3 = 3'($urandom);
        if (!allow_ill && op == OP_BR && f3[2:1] == 2'b01) f3 = 3'b000;
        run_instr(op, f3, 1'($urandom));
    endtask

    task automatic do_reset(input int n);
        outv_t e, m;
        rst = 1'b1;
        halted_h = 1'b0;
        model(OP_R, 3'd0, 1'b0, 1'b0, 0, op_d, e, m);
        e.pcw = 1'b0; e.irw = 1'b0;
        exp_h = e; exp_n = e; msk_h = m; msk_n = m;
        chk_en = 1'b1;
        #1;
        lit("reset_enables", 32'({if_h.PC_write, if_h.mem_write, if_h.IR_write, if_h.reg_write}), 32'd0);
        lit("reset_illegal", 32'(if_h.illegal), 32'd0);
        repeat (n) tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset(3);

        // R-type SUB, four cycles, then reset mid-EXECR.
        do_step(OP_R, 3'd0, 1'b1, 1'b0, 0);
        lit("fetch_irw", 32'(if_h.IR_write), 32'd1);
        lit("fetch_pcw", 32'(if_h.PC_write), 32'd1);
        tick();
        steps(OP_R, 3'd0, 1'b1, 1, 2);
        do_step(OP_R, 3'd0, 1'b1, 1'b0, 2);
        lit("execr_alu", 32'(if_h.ALU_control), 32'h1);
        lit("execr_srcs", 32'({if_h.ALU_src_A, if_h.ALU_src_B}), 32'b1000);
        tick();
        do_step(OP_R, 3'd0, 1'b1, 1'b0, 3);
        lit("aluwb_regw", 32'(if_h.reg_write), 32'd1);
        tick();
        steps(OP_R, 3'd0, 1'b1, 0, 2);
        do_step(OP_R, 3'd0, 1'b1, 1'b0, 2);
        do_reset(2);
        do_step(OP_I, 3'd5, 1'b1, 1'b0, 0);
        lit("post_reset_irw", 32'(if_h.IR_write), 32'd1);
        lit("post_reset_pcw", 32'(if_h.PC_write), 32'd1);
        lit("post_reset_alu", 32'(if_h.ALU_control), 32'h0);
        tick();
        steps(OP_I, 3'd5, 1'b1, 1, 4);

        // Branch resolution with forced zero flag.
        steps(OP_BR, 3'd0, 1'b0, 0, 2);
        do_step(OP_BR, 3'd0, 1'b0, 1'b1, 2);
        lit("beq_taken", 32'(if_h.PC_write), 32'd1);
        tick();
        steps(OP_BR, 3'd0, 1'b0, 0, 2);
        do_step(OP_BR, 3'd0, 1'b0, 1'b0, 2);
        lit("beq_not_taken", 32'(if_h.PC_write), 32'd0);
        tick();
        steps(OP_BR, 3'd4, 1'b0, 0, 2);
        do_step(OP_BR, 3'd4, 1'b0, 1'b0, 2);
        lit("blt_alu", 32'(if_h.ALU_control), 32'h9);
        lit("blt_taken", 32'(if_h.PC_write), 32'd1);
        tick();
        steps(OP_BR, 3'd7, 1'b0, 0, 2);
        do_step(OP_BR, 3'd7, 1'b0, 1'b0, 2);
        lit("bgeu_alu", 32'(if_h.ALU_control), 32'h8);
        lit("bgeu_not_taken", 32'(if_h.PC_write), 32'd0);
        tick();

        // Load and store.
        steps(OP_LOAD, 3'd2, 1'b0, 0, 3);
        do_step(OP_LOAD, 3'd2, 1'b0, 1'b0, 3);
        lit("memread_adr", 32'(if_h.adr_src), 32'd1);
        tick();
        do_step(OP_LOAD, 3'd2, 1'b0, 1'b0, 4);
        lit("memwb_res", 32'(if_h.result_src), 32'd1);
        lit("memwb_regw", 32'(if_h.reg_write), 32'd1);
        tick();
        steps(OP_STORE, 3'd2, 1'b0, 0, 3);
        do_step(OP_STORE, 3'd2, 1'b0, 1'b0, 3);
        lit("memwrite_en", 32'(if_h.mem_write), 32'd1);
        lit("store_imm", 32'(if_h.imm_src), 32'd1);
        tick();

        repeat (300) rand_instr(1'b0);

        // Unsupported opcode: one instance parks, the other resumes fetching.
        steps(7'h7f, 3'd0, 1'b0, 0, 2);
        do_step(7'h7f, 3'd0, 1'b0, 1'b0, 2);
        lit("illegal_halt", 32'(if_h.illegal), 32'd1);
        lit("illegal_nohalt", 32'(if_n.illegal), 32'd1);
        tick();
        do_step(OP_LUI, 3'd0, 1'b0, 1'b0, 0);
        lit("nohalt_refetch", 32'(if_n.IR_write), 32'd1);
        lit("halt_held", 32'(if_h.illegal), 32'd1);
        tick();
        steps(OP_LUI, 3'd0, 1'b0, 1, 4);
        pin_halt = 1'b1;
        repeat (4) rand_instr(1'b1);
        pin_halt = 1'b0;
        repeat (40) rand_instr(1'b1);

        do_reset(2);
        repeat (300) rand_instr(1'b1);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
